// File: rtl/result_serial.sv
`default_nettype none
// ==========================================================================
// result_serial : splits result vectors into STR_WIDTH beats, flags layer end
// Revision      : 1.0
// ==========================================================================
module result_serial #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int DEPTH_NB   = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int STR_WIDTH  = 64,
    parameter int CFG_RESULT = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
    input  logic                          result_val,
    output logic                          result_rdy,
    output logic [STR_WIDTH-1:0]          str_data,
    output logic                          str_last,
    output logic                          str_val,
    input  logic                          str_rdy,
    output logic                          layer_done
);

    localparam int VEC_W  = IMG_WIDTH * DEPTH_NB;
    localparam int BEATS  = VEC_W / STR_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_RESET = 3'b001,
        ST_IDLE  = 3'b010,
        ST_SEND  = 3'b100
    } state_t;

    state_t                            r_state;
    logic [BEAT_W-1:0]                 r_beat;
    logic [BEATS-1:0][STR_WIDTH-1:0]   r_hold;
    logic [15:0]                       r_vec_cnt;
    logic [15:0]                       r_vec_nb;
    logic                              r_layer_done;

    logic w_final_beat;
    logic w_cnt_wrap;
    logic w_last_vec;
    logic w_cfg_hit;
    logic w_unused;

    // vec_nb==0 makes vec_nb-1 all ones, so the counter wraps at 65535 silently
    assign w_final_beat = (r_beat == c_last_beat);
    assign w_cnt_wrap   = (r_vec_cnt == (r_vec_nb - 16'd1));
    assign w_last_vec   = (r_vec_nb != 16'd0) && w_cnt_wrap;
    assign w_cfg_hit    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RESULT));
    assign w_unused     = ^cfg_data[CFG_DWIDTH-1:16];

    assign result_rdy = (r_state == ST_IDLE);
    assign str_val    = (r_state == ST_SEND);
    assign str_data   = r_hold[r_beat];
    assign str_last   = (r_state == ST_SEND) && w_final_beat && w_last_vec;
    assign layer_done = r_layer_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RESET;
            r_beat       <= '0;
            r_vec_cnt    <= 16'd0;
            r_vec_nb     <= 16'd0;
            r_layer_done <= 1'b0;
        end else begin
            r_layer_done <= 1'b0;
            case (r_state)
                ST_RESET: r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (result_val) begin
                        r_hold  <= result_bus;
                        r_beat  <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (str_rdy) begin
                        if (!w_final_beat) begin
                            r_beat <= r_beat + 1'b1;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_layer_done <= w_last_vec;
                            r_vec_cnt    <= w_cnt_wrap ? 16'd0 : r_vec_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_RESET;
            endcase
            // A config write in the same cycle as the final beat overrides the count update
            if (w_cfg_hit) begin
                r_vec_nb  <= cfg_data[15:0];
                r_vec_cnt <= 16'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_serial.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for result_serial: scoreboard of expected beats, cycle checks on handshakes.
module tb_result_serial;

    localparam int CFG_DWIDTH = 32;
    localparam int CFG_AWIDTH = 5;
    localparam int DEPTH_NB   = 16;
    localparam int IMG_WIDTH  = 16;
    localparam int STR_WIDTH  = 64;
    localparam int CFG_RESULT = 12;
    localparam int VEC_W      = DEPTH_NB * IMG_WIDTH;
    localparam int BEATS      = VEC_W / STR_WIDTH;

    logic                  clk;
    logic                  rst;
    logic [CFG_DWIDTH-1:0] cfg_data;
    logic [CFG_AWIDTH-1:0] cfg_addr;
    logic                  cfg_valid;
    logic [VEC_W-1:0]      result_bus;
    logic                  result_val;
    logic                  result_rdy;
    logic [STR_WIDTH-1:0]  str_data;
    logic                  str_last;
    logic                  str_val;
    logic                  str_rdy;
    logic                  layer_done;

    result_serial #(
        .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .DEPTH_NB(DEPTH_NB),
        .IMG_WIDTH(IMG_WIDTH), .STR_WIDTH(STR_WIDTH), .CFG_RESULT(CFG_RESULT)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .result_bus(result_bus), .result_val(result_val), .result_rdy(result_rdy),
        .str_data(str_data), .str_last(str_last), .str_val(str_val), .str_rdy(str_rdy),
        .layer_done(layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [STR_WIDTH-1:0] data;
        logic                 last;
    } beat_t;

    beat_t                sb_q[$];
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   n_beats = 0;
    int                   n_last = 0;
    int                   n_done = 0;
    logic                 mon_en = 1'b0;
    logic                 pend_done = 1'b0;
    logic                 stall = 1'b0;
    logic [STR_WIDTH-1:0] st_data;
    logic                 st_last;
    logic [STR_WIDTH-1:0] obs_log [0:3];
    logic [15:0]          m_cnt = 16'd0;
    logic [15:0]          m_nb = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] v);
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(CFG_RESULT);
        cfg_data  = {16'hDEAD, v};
        step();
        cfg_valid = 1'b0;
        m_nb  = v;
        m_cnt = 16'd0;
    endtask

    // Returns in the cycle where beat 0 is first valid.
    task automatic send_vec(input logic [VEC_W-1:0] bus);
        beat_t e;
        int    i;
        for (i = 0; i < 200; i++) begin
            if (result_rdy === 1'b1) break;
            step();
        end
        chk("rdy_wait", {63'd0, result_rdy}, 64'd1);
        result_bus = bus;
        result_val = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            e.data = bus[b*STR_WIDTH +: STR_WIDTH];
            e.last = (b == BEATS - 1) && (m_nb != 16'd0) && (m_cnt == m_nb - 16'd1);
            sb_q.push_back(e);
        end
        m_cnt = (m_cnt == m_nb - 16'd1) ? 16'd0 : m_cnt + 16'd1;
        step();
        result_val = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0 && str_val === 1'b0) break;
            step();
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
        step();
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < VEC_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb_q.delete();
                pend_done = 1'b0;
                stall     = 1'b0;
            end else begin
                beat_t e;
                chk("layer_done", {63'd0, layer_done}, {63'd0, pend_done});
                if (layer_done === 1'b1) n_done++;
                if (stall) begin
                    chk("stall_val", {63'd0, str_val}, 64'd1);
                    chk("stall_data", str_data, st_data);
                    chk("stall_last", {63'd0, str_last}, {63'd0, st_last});
                end
                if (str_val === 1'b1) chk("rdy_excl", {63'd0, result_rdy}, 64'd0);
                pend_done = 1'b0;
                if (str_val === 1'b1 && str_rdy === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("beat_data", str_data, e.data);
                        chk("beat_last", {63'd0, str_last}, {63'd0, e.last});
                        pend_done = e.last;
                        obs_log[n_beats % 4] = str_data;
                        n_beats++;
                        if (str_last === 1'b1) n_last++;
                    end
                end
                stall   = (str_val === 1'b1) && (str_rdy !== 1'b1);
                st_data = str_data;
                st_last = str_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VEC_W-1:0] bus;
        int b0, l0, d0;
        logic [STR_WIDTH-1:0] exp_beats [0:3];
        exp_beats[0] = 64'h0003000200010000;
        exp_beats[1] = 64'h0007000600050004;
        exp_beats[2] = 64'h000B000A00090008;
        exp_beats[3] = 64'h000F000E000D000C;

        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        result_bus = '0; result_val = 1'b0; str_rdy = 1'b1;
        repeat (3) step();
        mon_en = 1'b1;
        chk("rst_result_rdy", {63'd0, result_rdy}, 64'd0);
        chk("rst_str_val", {63'd0, str_val}, 64'd0);
        chk("rst_str_last", {63'd0, str_last}, 64'd0);
        chk("rst_layer_done", {63'd0, layer_done}, 64'd0);
        rst = 1'b0;
        chk("rdy_reset_state", {63'd0, result_rdy}, 64'd0);
        step();
        chk("rdy_after_reset", {63'd0, result_rdy}, 64'd1);

        // Single vector, pixel i = i
        cfg_write(16'd1);
        for (int i = 0; i < DEPTH_NB; i++) bus[i*IMG_WIDTH +: IMG_WIDTH] = IMG_WIDTH'(i);
        send_vec(bus);
        chk("first_beat_valid", {63'd0, str_val}, 64'd1);
        repeat (3) step();
        chk("single_last", {63'd0, str_last}, 64'd1);
        step();
        chk("single_done", {63'd0, layer_done}, 64'd1);
        chk("single_rdy_back", {63'd0, result_rdy}, 64'd1);
        chk("single_val_low", {63'd0, str_val}, 64'd0);
        for (int k = 0; k < 4; k++) chk("single_beat_const", obs_log[k], exp_beats[k]);

        // Backpressure on beat 1
        send_vec(rand_vec());
        step();
        str_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_result_rdy", {63'd0, result_rdy}, 64'd0);
        end
        str_rdy = 1'b1;
        b0 = n_beats;
        wait_drain();
        chk("bp_beats", 64'(n_beats - b0), 64'd3);

        // Layer counting: vec_nb=3, four vectors
        cfg_write(16'd3);
        l0 = n_last;
        for (int v = 0; v < 4; v++) send_vec(rand_vec());
        wait_drain();
        chk("count_lasts", 64'(n_last - l0), 64'd1);
        chk("count_vec_cnt", {48'd0, dut.r_vec_cnt}, 64'd1);

        // Config write racing the final beat of the layer
        cfg_write(16'd1);
        send_vec(rand_vec());
        repeat (3) step();
        chk("race_last", {63'd0, str_last}, 64'd1);
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(CFG_RESULT);
        cfg_data  = 32'd2;
        step();
        cfg_valid = 1'b0;
        m_nb = 16'd2;
        m_cnt = 16'd0;
        chk("race_done", {63'd0, layer_done}, 64'd1);
        chk("race_vec_cnt", {48'd0, dut.r_vec_cnt}, 64'd0);
        chk("race_vec_nb", {48'd0, dut.r_vec_nb}, 64'd2);
        l0 = n_last;
        send_vec(rand_vec());
        send_vec(rand_vec());
        wait_drain();
        chk("race_lasts", 64'(n_last - l0), 64'd1);

        // Reset in the middle of beat 2
        cfg_write(16'd1);
        send_vec(rand_vec());
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_val", {63'd0, str_val}, 64'd0);
        chk("mid_rst_rdy0", {63'd0, result_rdy}, 64'd0);
        step();
        chk("mid_rst_rdy1", {63'd0, result_rdy}, 64'd1);
        m_cnt = 16'd0;
        m_nb  = 16'd0;
        chk("mid_rst_vec_cnt", {48'd0, dut.r_vec_cnt}, 64'd0);
        chk("mid_rst_vec_nb", {48'd0, dut.r_vec_nb}, 64'd0);
        l0 = n_last;
        send_vec(rand_vec());
        send_vec(rand_vec());
        wait_drain();
        chk("mid_rst_lasts", 64'(n_last - l0), 64'd0);

        // vec_nb = 0: never a last beat
        cfg_write(16'd0);
        b0 = n_beats; l0 = n_last; d0 = n_done;
        for (int v = 0; v < 3; v++) send_vec(rand_vec());
        wait_drain();
        chk("nb0_beats", 64'(n_beats - b0), 64'd12);
        chk("nb0_lasts", 64'(n_last - l0), 64'd0);
        chk("nb0_done", 64'(n_done - d0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
